// File: rtl/v810_arb_pkg.sv
// v810_arb_pkg: shared types and constants for the V810 memory arbiter.
package v810_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_DONE = 2'd2
    } arb_state_e;

    typedef enum logic {
        REQ_I = 1'b0,
        REQ_D = 1'b1
    } arb_req_e;

    // Byte enables are active-low, so reset leaves every lane disabled
    localparam logic [3:0] M_BEN_RST = 4'hF;

    // Width of the access-latency down-counter (MEM_LAT up to 15)
    localparam int CNT_W = 4;

endpackage

// File: rtl/v810_arb_sel.sv
// v810_arb_sel: winner selection between fetch and data requesters.
// Build option V810_ARB_FAIR_EN adds a streak counter that hands a contested
// arbitration to fetch after STARVE_MAX data grants made while fetch waited.
module v810_arb_sel
    import v810_arb_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
`ifdef V810_ARB_FAIR_EN
    input  logic     clk,
    input  logic     rst_n,
    input  logic     grant_en,
    input  logic     i_req,
`endif
    input  logic     d_req,
    output arb_req_e win
);

`ifdef V810_ARB_FAIR_EN
    localparam int SW = $clog2(STARVE_MAX + 1);

    logic [SW-1:0] streak_r;
    logic          starved_s;

    // Data wins unless fetch is also pending and has waited STARVE_MAX grants
    always_comb begin
        starved_s = (streak_r == SW'(STARVE_MAX));
        if (d_req && !(i_req && starved_s)) begin
            win = REQ_D;
        end else begin
            win = REQ_I;
        end
    end

    // Count data grants that made fetch wait; any other grant breaks the streak
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            streak_r <= {SW{1'b0}};
        end else if (grant_en) begin
            if ((win == REQ_D) && i_req) begin
                streak_r <= streak_r + 1'b1;
            end else begin
                streak_r <= {SW{1'b0}};
            end
        end
    end
`else
    // Strict data priority
    always_comb begin
        if (d_req) begin
            win = REQ_D;
        end else begin
            win = REQ_I;
        end
    end
`endif

endmodule

// File: rtl/v810_mem_arb.sv
// v810_mem_arb: arbitrates a fetch port and a data port onto one unified
// memory port; one access outstanding at a time, IDLE -> ACC -> DONE.
// Build option: define V810_ARB_FAIR_EN to bound fetch starvation.
module v810_mem_arb
    import v810_arb_pkg::*;
#(
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic        CLK,
    input  logic        RESn,
    input  logic        CE,
    input  logic        I_REQ,
    input  logic [31:0] I_A,
    output logic [31:0] I_D,
    output logic        I_RDY,
    input  logic        D_REQ,
    input  logic [31:0] D_A,
    input  logic        D_RW,
    input  logic [3:0]  D_BEn,
    input  logic [31:0] D_DO,
    output logic [31:0] D_DI,
    output logic        D_RDY,
    output logic [31:0] M_A,
    output logic        M_RW,
    output logic [3:0]  M_BEn,
    output logic        M_MRQn,
    output logic [31:0] M_DO,
    input  logic [31:0] M_DI,
    output logic        BUSY
);

    localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(MEM_LAT);

    arb_state_e       state_r;
    arb_req_e         winner_r;
    arb_req_e         win_s;
    logic [CNT_W-1:0] cnt_r;

`ifdef V810_ARB_FAIR_EN
    logic grant_en_s;

    // An arbitration is consumed only on an enabled IDLE edge with a request
    always_comb begin
        grant_en_s = 1'b0;
        if (CE && (state_r == ST_IDLE) && (I_REQ || D_REQ)) begin
            grant_en_s = 1'b1;
        end else begin
            grant_en_s = 1'b0;
        end
    end
`endif

    v810_arb_sel #(
        .STARVE_MAX (STARVE_MAX)
    ) u_sel (
`ifdef V810_ARB_FAIR_EN
        .clk      (CLK),
        .rst_n    (RESn),
        .grant_en (grant_en_s),
        .i_req    (I_REQ),
`endif
        .d_req    (D_REQ),
        .win      (win_s)
    );

    // Access FSM; the M_* outputs double as the latches for the granted access
    always_ff @(posedge CLK or negedge RESn) begin
        if (!RESn) begin
            state_r  <= ST_IDLE;
            winner_r <= REQ_I;
            cnt_r    <= {CNT_W{1'b0}};
            M_A      <= 32'h0000_0000;
            M_RW     <= 1'b1;
            M_BEn    <= M_BEN_RST;
            M_MRQn   <= 1'b1;
            M_DO     <= 32'h0000_0000;
            I_D      <= 32'h0000_0000;
            D_DI     <= 32'h0000_0000;
            I_RDY    <= 1'b0;
            D_RDY    <= 1'b0;
            BUSY     <= 1'b0;
        end else if (CE) begin
            case (state_r)
                ST_IDLE: begin
                    I_RDY <= 1'b0;
                    D_RDY <= 1'b0;
                    if (I_REQ || D_REQ) begin
                        winner_r <= win_s;
                        if (win_s == REQ_D) begin
                            M_A   <= D_A;
                            M_RW  <= D_RW;
                            M_BEn <= D_BEn;
                            M_DO  <= D_DO;
                        end else begin
                            M_A   <= I_A;
                            M_RW  <= 1'b1;
                            M_BEn <= 4'b0000;
                            M_DO  <= 32'h0000_0000;
                        end
                        M_MRQn  <= 1'b0;
                        cnt_r   <= LAT_LOAD;
                        BUSY    <= 1'b1;
                        state_r <= ST_ACC;
                    end
                end
                ST_ACC: begin
                    if (cnt_r == 4'd1) begin
                        M_MRQn  <= 1'b1;
                        M_RW    <= 1'b1;
                        cnt_r   <= {CNT_W{1'b0}};
                        state_r <= ST_DONE;
                        if (winner_r == REQ_I) begin
                            I_D   <= M_DI;
                            I_RDY <= 1'b1;
                        end else begin
                            if (M_RW) begin
                                D_DI <= M_DI;
                            end
                            D_RDY <= 1'b1;
                        end
                    end else begin
                        cnt_r <= cnt_r - 4'd1;
                    end
                end
                ST_DONE: begin
                    I_RDY   <= 1'b0;
                    D_RDY   <= 1'b0;
                    BUSY    <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    I_RDY   <= 1'b0;
                    D_RDY   <= 1'b0;
                    BUSY    <= 1'b0;
                    M_MRQn  <= 1'b1;
                    M_RW    <= 1'b1;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_v810_mem_arb.sv
// tb_v810_mem_arb: scoreboard bench for v810_mem_arb with a behavioural
// memory behind the unified port. Expectations are derived from LAT.
module tb_v810_mem_arb;

    localparam int LAT  = 2;
    localparam int SMAX = 4;

    logic        CLK, RESn, CE;
    logic        I_REQ, I_RDY, D_REQ, D_RDY, D_RW, M_RW, M_MRQn, BUSY;
    logic [31:0] I_A, I_D, D_A, D_DO, D_DI, M_A, M_DO, M_DI;
    logic [3:0]  D_BEn, M_BEn;

    v810_mem_arb #(.MEM_LAT(LAT), .STARVE_MAX(SMAX)) dut (
        .CLK(CLK), .RESn(RESn), .CE(CE),
        .I_REQ(I_REQ), .I_A(I_A), .I_D(I_D), .I_RDY(I_RDY),
        .D_REQ(D_REQ), .D_A(D_A), .D_RW(D_RW), .D_BEn(D_BEn), .D_DO(D_DO),
        .D_DI(D_DI), .D_RDY(D_RDY),
        .M_A(M_A), .M_RW(M_RW), .M_BEn(M_BEn), .M_MRQn(M_MRQn), .M_DO(M_DO),
        .M_DI(M_DI), .BUSY(BUSY)
    );

    typedef struct packed {
        logic        is_d;
        logic [31:0] data;
    } exp_t;

    exp_t        sb[$];
    int          errors = 0;
    int          checks = 0;
    logic [31:0] mem [0:255];
    logic        mem_init;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [31:0] mem_pat(input int i);
        case (i)
            1:       return 32'hA5A5_0001;
            2:       return 32'h1234_5678;
            3:       return 32'hC0DE_0003;
            28:      return 32'hFFFF_FFFF;
            default: return 32'h5000_0000 | 32'(i);
        endcase
    endfunction

    function automatic exp_t mk(input logic is_d, input logic [31:0] data);
        exp_t e;
        e.is_d = is_d;
        e.data = data;
        return e;
    endfunction

    assign M_DI = mem[M_A[9:2]];

    // Behavioural memory: preload, then byte-lane writes while a write is asserted
    always @(posedge CLK) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= mem_pat(i);
        end else if (CE && !M_MRQn && !M_RW) begin
            for (int b = 0; b < 4; b++)
                if (!M_BEn[b]) mem[M_A[9:2]][8*b +: 8] <= M_DO[8*b +: 8];
        end
    end

    // Step negedges until a RDY pulse or the budget expires (n = -1); no checking here
    task automatic wait_rdy(input int budget, output int n, output bit gi, output bit gd,
                            output int lo, output int rw0, output bit ov);
        n = -1; gi = 1'b0; gd = 1'b0; lo = 0; rw0 = 0; ov = 1'b0;
        for (int c = 1; c <= budget; c++) begin
            @(negedge CLK);
            if (I_RDY && D_RDY) ov = 1'b1;
            if (I_RDY || D_RDY) begin
                n = c; gi = I_RDY; gd = D_RDY;
                break;
            end
            if (!M_MRQn) begin
                lo++;
                if (!M_RW) rw0++;
            end
        end
    endtask

    task automatic test_reset();
        checks++;
        if ({M_MRQn, M_RW, M_BEn, I_RDY, D_RDY, BUSY} !== 9'b1_1_1111_000) begin
            errors++;
            $display("FAIL reset_ctrl: got %b want 111111000", {M_MRQn, M_RW, M_BEn, I_RDY, D_RDY, BUSY});
        end
        checks++;
        if ({M_A, M_DO, I_D, D_DI} !== 128'h0) begin
            errors++;
            $display("FAIL reset_data: got %h want 0", {M_A, M_DO, I_D, D_DI});
        end
    endtask

    task automatic test_fetch();
        int n, lo, rw0; bit gi, gd, ov; exp_t e;
        I_A = 32'h8; I_REQ = 1'b1;
        sb.push_back(mk(1'b0, mem_pat(2)));
        wait_rdy(20, n, gi, gd, lo, rw0, ov);
        I_REQ = 1'b0;
        e = sb.pop_front();
        checks++; if (n !== LAT + 1) begin errors++; $display("FAIL fetch_latency: got %0d want %0d", n, LAT + 1); end
        checks++; if (lo !== LAT) begin errors++; $display("FAIL fetch_mrq_low: got %0d want %0d", lo, LAT); end
        checks++; if ({gi, gd} !== (e.is_d ? 2'b01 : 2'b10)) begin errors++; $display("FAIL fetch_port: got %b", {gi, gd}); end
        checks++; if (I_D !== e.data) begin errors++; $display("FAIL fetch_data: got %h want %h", I_D, e.data); end
        @(negedge CLK);
        checks++;
        if ({I_RDY, BUSY, M_MRQn, M_RW, M_BEn, M_A} !== {4'b0011, 4'b0000, 32'h8}) begin
            errors++;
            $display("FAIL fetch_idle_hold: got %b %h", {I_RDY, BUSY, M_MRQn, M_RW, M_BEn}, M_A);
        end
    endtask

    task automatic test_contest();
        int n, lo, rw0; bit gi, gd, ov; exp_t e;
        I_A = 32'hC; D_A = 32'h4; D_RW = 1'b1; D_BEn = 4'h0; I_REQ = 1'b1; D_REQ = 1'b1;
        sb.push_back(mk(1'b1, mem_pat(1)));
        sb.push_back(mk(1'b0, mem_pat(3)));
        wait_rdy(20, n, gi, gd, lo, rw0, ov);
        D_REQ = 1'b0;
        e = sb.pop_front();
        checks++; if ({gi, gd} !== (e.is_d ? 2'b01 : 2'b10)) begin errors++; $display("FAIL contest_first_port: got %b", {gi, gd}); end
        checks++; if (D_DI !== e.data) begin errors++; $display("FAIL contest_d_data: got %h want %h", D_DI, e.data); end
        checks++; if (n !== LAT + 1) begin errors++; $display("FAIL contest_d_latency: got %0d want %0d", n, LAT + 1); end
        wait_rdy(20, n, gi, gd, lo, rw0, ov);
        I_REQ = 1'b0;
        e = sb.pop_front();
        checks++; if ({gi, gd, ov} !== (e.is_d ? 3'b010 : 3'b100)) begin errors++; $display("FAIL contest_second_port: got %b", {gi, gd, ov}); end
        checks++; if (I_D !== e.data) begin errors++; $display("FAIL contest_i_data: got %h want %h", I_D, e.data); end
        checks++; if (n !== LAT + 2) begin errors++; $display("FAIL contest_i_gap: got %0d want %0d", n, LAT + 2); end
    endtask

    task automatic test_write();
        int n, lo, rw0, extra; bit gi, gd, ov; exp_t e;
        D_A = 32'h70; D_DO = 32'h9; D_BEn = 4'h0; D_RW = 1'b0; D_REQ = 1'b1;
        sb.push_back(mk(1'b1, 32'h0000_0009));
        wait_rdy(20, n, gi, gd, lo, rw0, ov);
        D_REQ = 1'b0;
        e = sb.pop_front();
        checks++; if ({gi, gd} !== 2'b01) begin errors++; $display("FAIL write_port: got %b want 01", {gi, gd}); end
        checks++; if (rw0 !== LAT) begin errors++; $display("FAIL write_rw_low: got %0d want %0d", rw0, LAT); end
        checks++; if (mem[28] !== e.data) begin errors++; $display("FAIL write_mem: got %h want %h", mem[28], e.data); end
        checks++; if (D_DI !== mem_pat(1)) begin errors++; $display("FAIL write_di_hold: got %h want %h", D_DI, mem_pat(1)); end
        extra = 0;
        repeat (6) begin @(negedge CLK); if (I_RDY || D_RDY) extra++; end
        checks++; if (extra !== 0) begin errors++; $display("FAIL write_single_pulse: got %0d extra want 0", extra); end
        D_DO = 32'h1122_3344; D_BEn = 4'b1100; D_REQ = 1'b1;
        sb.push_back(mk(1'b1, 32'h0000_3344));
        wait_rdy(20, n, gi, gd, lo, rw0, ov);
        D_REQ = 1'b0; D_RW = 1'b1;
        e = sb.pop_front();
        checks++; if (mem[28] !== e.data) begin errors++; $display("FAIL write_bytelane: got %h want %h", mem[28], e.data); end
    endtask

    task automatic test_starve();
        int n, lo, rw0, streak, i_cnt, total; bit gi, gd, ov; exp_t e; logic exp_d;
`ifdef V810_ARB_FAIR_EN
        total = 10;
`else
        total = 20;
`endif
        streak = 0; i_cnt = 0;
        I_A = 32'h8; D_A = 32'h4; D_RW = 1'b1; D_BEn = 4'h0; I_REQ = 1'b1; D_REQ = 1'b1;
        for (int k = 0; k < total; k++) begin
`ifdef V810_ARB_FAIR_EN
            exp_d = (streak != SMAX);
            streak = exp_d ? streak + 1 : 0;
`else
            exp_d = 1'b1;
`endif
            sb.push_back(mk(exp_d, exp_d ? mem_pat(1) : mem_pat(2)));
            wait_rdy(20, n, gi, gd, lo, rw0, ov);
            if (k == total - 1) begin I_REQ = 1'b0; D_REQ = 1'b0; end
            if (gi) i_cnt++;
            e = sb.pop_front();
            checks++;
            if ({gi, gd} !== (e.is_d ? 2'b01 : 2'b10) || (gi ? I_D : D_DI) !== e.data) begin
                errors++;
                $display("FAIL starve_access_%0d: got rdy=%b data=%h want d=%b data=%h", k, {gi, gd}, gi ? I_D : D_DI, e.is_d, e.data);
            end
        end
        checks++;
`ifdef V810_ARB_FAIR_EN
        if (i_cnt !== 2) begin errors++; $display("FAIL starve_fetch_count: got %0d want 2", i_cnt); end
`else
        if (i_cnt !== 0) begin errors++; $display("FAIL starve_fetch_count: got %0d want 0", i_cnt); end
`endif
        repeat (2) @(negedge CLK);
    endtask

    task automatic test_ce_stall();
        int n, lo, rw0, lo_tot, held; bit gi, gd, ov; exp_t e;
        D_A = 32'h4; D_RW = 1'b1; D_BEn = 4'h0; D_REQ = 1'b1;
        sb.push_back(mk(1'b1, mem_pat(1)));
        @(negedge CLK);
        lo_tot = M_MRQn ? 0 : 1;
        CE = 1'b0;
        repeat (3) begin @(negedge CLK); if (!M_MRQn) lo_tot++; end
        CE = 1'b1;
        wait_rdy(20, n, gi, gd, lo, rw0, ov);
        D_REQ = 1'b0;
        lo_tot += lo;
        e = sb.pop_front();
        checks++; if (n !== LAT) begin errors++; $display("FAIL ce_rdy_delay: got %0d want %0d", n, LAT); end
        checks++; if (lo_tot !== LAT + 3) begin errors++; $display("FAIL ce_mrq_low: got %0d want %0d", lo_tot, LAT + 3); end
        checks++; if ({gi, gd} !== 2'b01 || D_DI !== e.data) begin errors++; $display("FAIL ce_data: got %b %h want 01 %h", {gi, gd}, D_DI, e.data); end
        CE = 1'b0; held = 0;
        repeat (2) begin @(negedge CLK); if (D_RDY) held++; end
        CE = 1'b1;
        @(negedge CLK);
        checks++; if ({held, D_RDY} !== {32'd2, 1'b0}) begin errors++; $display("FAIL ce_rdy_extend: got held=%0d rdy=%b want 2 0", held, D_RDY); end
    endtask

    task automatic test_reset_mid();
        int n, lo, rw0, cnt; bit gi, gd, ov; exp_t e;
        D_A = 32'h4; D_RW = 1'b1; D_REQ = 1'b1;
        @(negedge CLK);
        checks++; if (M_MRQn !== 1'b0) begin errors++; $display("FAIL rst_mid_in_acc: got %b want 0", M_MRQn); end
        #1 RESn = 1'b0; D_REQ = 1'b0;
        #1;
        checks++;
        if ({M_MRQn, M_RW, M_BEn, BUSY, I_RDY, D_RDY, M_A, M_DO, I_D, D_DI} !== {9'b1_1_1111_000, 128'h0}) begin
            errors++;
            $display("FAIL rst_mid_force: got %b %h", {M_MRQn, M_RW, M_BEn, BUSY, I_RDY, D_RDY}, {M_A, M_DO, I_D, D_DI});
        end
        @(negedge CLK);
        RESn = 1'b1;
        cnt = 0;
        repeat (2 * LAT + 4) begin @(negedge CLK); if (I_RDY || D_RDY) cnt++; end
        checks++; if (cnt !== 0) begin errors++; $display("FAIL rst_mid_no_rdy: got %0d want 0", cnt); end
        I_A = 32'hC; I_REQ = 1'b1;
        sb.push_back(mk(1'b0, mem_pat(3)));
        wait_rdy(20, n, gi, gd, lo, rw0, ov);
        I_REQ = 1'b0;
        e = sb.pop_front();
        checks++;
        if ({gi, gd} !== 2'b10 || I_D !== e.data || n !== LAT + 1) begin
            errors++;
            $display("FAIL rst_mid_recover: got %b %h n=%0d want 10 %h n=%0d", {gi, gd}, I_D, n, e.data, LAT + 1);
        end
    endtask

    initial begin
        RESn = 1'b0; CE = 1'b1; mem_init = 1'b1;
        I_REQ = 1'b0; I_A = 32'h0; D_REQ = 1'b0; D_A = 32'h0;
        D_RW = 1'b1; D_BEn = 4'hF; D_DO = 32'h0;
        repeat (2) @(negedge CLK);
        test_reset();
        mem_init = 1'b0; RESn = 1'b1;
        @(negedge CLK);
        test_fetch();
        test_contest();
        test_write();
        test_starve();
        test_ce_stall();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
